// File: rtl/feature_pkg.sv
// Shared state encoding and default sizes for the feature streamer.
// Optional delta stage is selected with FEATURE_STREAMER_DELTA_EN.
package feature_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_NUM_FEATURES = 13;

`ifdef FEATURE_STREAMER_DELTA_EN
    typedef enum logic [1:0] {StCapture, StEmitStatic, StEmitDelta} stream_state_e;
`else
    typedef enum logic [1:0] {StCapture, StEmitStatic} stream_state_e;
`endif

endpackage

// File: rtl/feature_history.sv
// Three-bank rotating frame store: current frame plus the two previous frames.
// Instantiated by feature_streamer only when FEATURE_STREAMER_DELTA_EN is defined.
module feature_history
    import feature_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int NUM_FEATURES = DEFAULT_NUM_FEATURES,
    localparam int SW          = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [SW-1:0]         wr_slot,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rotate,
    input  logic [SW-1:0]         rd_slot,
    output logic [DATA_WIDTH-1:0] cur_word,
    output logic [DATA_WIDTH-1:0] old_word
);

    logic [DATA_WIDTH-1:0] cur_q  [NUM_FEATURES];
    logic [DATA_WIDTH-1:0] prev_q [NUM_FEATURES];
    logic [DATA_WIDTH-1:0] old_q  [NUM_FEATURES];

    // Rotation also clears the current bank so a short next frame reads zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                cur_q[i]  <= '0;
                prev_q[i] <= '0;
                old_q[i]  <= '0;
            end
        end else if (rotate) begin
            for (int i = 0; i < NUM_FEATURES; i++) begin
                old_q[i]  <= prev_q[i];
                prev_q[i] <= cur_q[i];
                cur_q[i]  <= '0;
            end
        end else if (wr_en) begin
            cur_q[wr_slot] <= wr_data;
        end
    end

    assign cur_word = cur_q[rd_slot];
    assign old_word = old_q[rd_slot];

endmodule

// File: rtl/feature_streamer.sv
// Captures one coefficient frame, then streams the kept features (and, with
// FEATURE_STREAMER_DELTA_EN, their two-frame deltas) over a valid/ready port.
module feature_streamer
    import feature_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int NUM_COEFFS_IN = 26,
    parameter int NUM_FEATURES  = DEFAULT_NUM_FEATURES,
    parameter int SKIP_C0       = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] coeff_data_in,
    input  logic                  coeff_valid_in,
    input  logic                  coeff_last_in,
    output logic                  coeff_ready_out,
    output logic [DATA_WIDTH-1:0] feature_data_out,
    output logic                  feature_valid_out,
    output logic                  feature_last_out,
    input  logic                  feature_ready_in,
    output logic                  frame_error_out
);

    localparam int SW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int KW = $clog2(NUM_COEFFS_IN + 1);
    localparam logic [KW-1:0] KMax      = KW'(NUM_COEFFS_IN);
    localparam logic [KW-1:0] KLast     = KW'(NUM_COEFFS_IN - 1);
    localparam logic [SW-1:0] SlotLast  = SW'(NUM_FEATURES - 1);

    stream_state_e         state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [SW-1:0]         idx_q, idx_d;
    logic                  error_q, error_d;
    logic                  final_hs;
    logic                  wr_en;
    logic [SW-1:0]         wr_slot;
    logic [DATA_WIDTH-1:0] cur_word;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StCapture;
            k_q     <= '0;
            idx_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        idx_d    = idx_q;
        error_d  = 1'b0;
        final_hs = 1'b0;
        unique case (state_q)
            StCapture: begin
                if (coeff_valid_in) begin
                    if (k_q != KMax) k_d = k_q + KW'(1);
                    if (coeff_last_in) begin
                        state_d = StEmitStatic;
                        idx_d   = '0;
                        // Correct only when last is exactly the NUM_COEFFS_IN-th word.
                        error_d = (k_q != KLast);
                    end
                end
            end
            StEmitStatic: begin
                if (feature_ready_in) begin
                    if (idx_q == SlotLast) begin
                        idx_d = '0;
`ifdef FEATURE_STREAMER_DELTA_EN
                        state_d = StEmitDelta;
`else
                        final_hs = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + SW'(1);
                    end
                end
            end
`ifdef FEATURE_STREAMER_DELTA_EN
            StEmitDelta: begin
                if (feature_ready_in) begin
                    if (idx_q == SlotLast) final_hs = 1'b1;
                    else idx_d = idx_q + SW'(1);
                end
            end
`endif
            default: state_d = StCapture;
        endcase
        if (final_hs) begin
            state_d = StCapture;
            k_d     = '0;
            idx_d   = '0;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_slot = '0;
        if (state_q == StCapture && coeff_valid_in &&
            int'(k_q) >= SKIP_C0 && int'(k_q) < SKIP_C0 + NUM_FEATURES) begin
            wr_en   = 1'b1;
            wr_slot = SW'(int'(k_q) - SKIP_C0);
        end
    end

`ifdef FEATURE_STREAMER_DELTA_EN
    logic [1:0]            frames_q;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] delta_word;
    logic [DATA_WIDTH:0]   diff;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) frames_q <= '0;
        else if (final_hs && frames_q != 2'd2) frames_q <= frames_q + 2'd1;
    end

    feature_history #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_FEATURES (NUM_FEATURES)
    ) u_history (
        .clk      (clk_in),
        .rst_n    (rst_n_in),
        .wr_en    (wr_en),
        .wr_slot  (wr_slot),
        .wr_data  (coeff_data_in),
        .rotate   (final_hs),
        .rd_slot  (idx_q),
        .cur_word (cur_word),
        .old_word (old_word)
    );

    // Sign-extended difference; bits [W:1] are the floor-halved result.
    assign diff       = {cur_word[DATA_WIDTH-1], cur_word} - {old_word[DATA_WIDTH-1], old_word};
    assign delta_word = (frames_q == 2'd2) ? diff[DATA_WIDTH:1] : '0;
`else
    logic [DATA_WIDTH-1:0] cur_q [NUM_FEATURES];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_FEATURES; i++) cur_q[i] <= '0;
        end else if (final_hs) begin
            for (int i = 0; i < NUM_FEATURES; i++) cur_q[i] <= '0;
        end else if (wr_en) begin
            cur_q[wr_slot] <= coeff_data_in;
        end
    end

    assign cur_word = cur_q[idx_q];
`endif

    always_comb begin
        coeff_ready_out   = (state_q == StCapture);
        feature_valid_out = (state_q != StCapture);
        feature_data_out  = '0;
        feature_last_out  = 1'b0;
        frame_error_out   = error_q;
        unique case (state_q)
            StEmitStatic: begin
                feature_data_out = cur_word;
`ifndef FEATURE_STREAMER_DELTA_EN
                feature_last_out = (idx_q == SlotLast);
`endif
            end
`ifdef FEATURE_STREAMER_DELTA_EN
            StEmitDelta: begin
                feature_data_out = delta_word;
                feature_last_out = (idx_q == SlotLast);
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_feature_streamer.sv
// Scoreboard bench for feature_streamer: default instance plus a SKIP_C0=1 instance.
module tb_feature_streamer;

    localparam int DW = 16;
    localparam int NF = 13;
`ifdef FEATURE_STREAMER_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] coeff_data = '0;
    logic          coeff_valid = 1'b0;
    logic          coeff_last = 1'b0;
    logic          feature_ready = 1'b1;
    logic          ready_a, valid_a, last_a, err_a;
    logic          ready_b, valid_b, last_b, err_b;
    logic [DW-1:0] data_a, data_b;

    int   errors = 0;
    int   checks = 0;
    int   hs_a = 0;
    int   err_pulses_a = 0;
    int   err_pulses_b = 0;
    bit   rand_ready = 1'b0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    int   frame_vals[$];
    logic signed [DW-1:0] h1 [2][NF];
    logic signed [DW-1:0] h2 [2][NF];
    int   frames_m [2];

    always #5 clk = ~clk;

    feature_streamer dut_a (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .coeff_data_in     (coeff_data),
        .coeff_valid_in    (coeff_valid),
        .coeff_last_in     (coeff_last),
        .coeff_ready_out   (ready_a),
        .feature_data_out  (data_a),
        .feature_valid_out (valid_a),
        .feature_last_out  (last_a),
        .feature_ready_in  (feature_ready),
        .frame_error_out   (err_a)
    );

    feature_streamer #(.SKIP_C0(1)) dut_b (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .coeff_data_in     (coeff_data),
        .coeff_valid_in    (coeff_valid),
        .coeff_last_in     (coeff_last),
        .coeff_ready_out   (ready_b),
        .feature_data_out  (data_b),
        .feature_valid_out (valid_b),
        .feature_last_out  (last_b),
        .feature_ready_in  (feature_ready),
        .frame_error_out   (err_b)
    );

    // Downstream ready changes shortly after each rising edge.
    initial forever begin
        @(posedge clk);
        #2;
        feature_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor for the default instance: scoreboard plus stall-hold check.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    exp_t          ea;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (err_a) err_pulses_a++;
            if (prev_stall) begin
                checks++;
                if (valid_a !== 1'b1 || data_a !== prev_data || last_a !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                             valid_a, data_a, last_a, prev_data, prev_last);
                end
            end
            if (valid_a && feature_ready) begin
                hs_a++;
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL out_a: got data=%h last=%b, need no output", data_a, last_a);
                end else begin
                    ea = exp_a.pop_front();
                    if (data_a !== ea.data || last_a !== ea.last) begin
                        errors++;
                        $display("FAIL out_a: got data=%h last=%b, need data=%h last=%b",
                                 data_a, last_a, ea.data, ea.last);
                    end
                end
            end
            prev_stall = valid_a && !feature_ready;
            prev_data  = data_a;
            prev_last  = last_a;
        end
    end

    exp_t eb;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (err_b) err_pulses_b++;
            if (valid_b && feature_ready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL out_skip: got data=%h last=%b, need no output", data_b, last_b);
                end else begin
                    eb = exp_b.pop_front();
                    if (data_b !== eb.data || last_b !== eb.last) begin
                        errors++;
                        $display("FAIL out_skip: got data=%h last=%b, need data=%h last=%b",
                                 data_b, last_b, eb.data, eb.last);
                    end
                end
            end
        end
    end

    // Reference model: slot selection, floor-halved two-frame delta, history rotation.
    task automatic model_frame();
        logic signed [DW-1:0] cur [NF];
        exp_t e;
        int   c, p, d;
        for (int inst = 0; inst < 2; inst++) begin
            for (int i = 0; i < NF; i++) cur[i] = '0;
            for (int k = 0; k < frame_vals.size(); k++)
                if (k >= inst && k < inst + NF) cur[k - inst] = DW'(frame_vals[k]);
            for (int i = 0; i < NF; i++) begin
                e.data = cur[i];
                e.last = !DELTA && (i == NF - 1);
                if (inst == 0) exp_a.push_back(e);
                else exp_b.push_back(e);
            end
            if (DELTA) begin
                for (int i = 0; i < NF; i++) begin
                    c = int'(cur[i]);
                    p = int'(h2[inst][i]);
                    d = c - p;
                    if (d < 0 && (d % 2) != 0) d = d / 2 - 1;
                    else d = d / 2;
                    if (frames_m[inst] < 2) d = 0;
                    e.data = DW'(d);
                    e.last = (i == NF - 1);
                    if (inst == 0) exp_a.push_back(e);
                    else exp_b.push_back(e);
                end
            end
            for (int i = 0; i < NF; i++) begin
                h2[inst][i] = h1[inst][i];
                h1[inst][i] = cur[i];
            end
            if (frames_m[inst] < 2) frames_m[inst]++;
        end
    endtask

    task automatic model_clear();
        exp_a.delete();
        exp_b.delete();
        for (int inst = 0; inst < 2; inst++) begin
            frames_m[inst] = 0;
            for (int i = 0; i < NF; i++) begin
                h1[inst][i] = '0;
                h2[inst][i] = '0;
            end
        end
    endtask

    task automatic send_frame();
        int guard;
        model_frame();
        for (int i = 0; i < frame_vals.size(); i++) begin
            coeff_valid = 1'b1;
            coeff_data  = DW'(frame_vals[i]);
            coeff_last  = (i == frame_vals.size() - 1);
            guard = 0;
            while (!(ready_a && ready_b) && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) begin
                checks++;
                errors++;
                $display("FAIL coeff_accept: got ready=0 after %0d cycles, need ready=1", guard);
                break;
            end
            @(negedge clk);
        end
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL drain: got pending a=%0d skip=%0d, need 0 0", exp_a.size(), exp_b.size());
        end
        repeat (2) @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: got %b, need 0", valid_a);
        end
    endtask

    task automatic ramp(input int n);
        frame_vals.delete();
        for (int i = 0; i < n; i++) frame_vals.push_back(i);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, need 0", valid_a); end
        if (last_a !== 1'b0) begin errors++; $display("FAIL rst_last: got %b, need 0", last_a); end
        if (data_a !== '0) begin errors++; $display("FAIL rst_data: got %h, need 0", data_a); end
        if (err_a !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, need 0", err_a); end
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (ready_a !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, need 1", ready_a); end
        if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_idle: got %b, need 0", valid_a); end
    endtask

    task automatic test_ramp();
        int e0 = err_pulses_a;
        ramp(26);
        send_frame();
        wait_drain();
        checks++;
        if (err_pulses_a !== e0) begin
            errors++;
            $display("FAIL ramp_err: got %0d pulses, need 0", err_pulses_a - e0);
        end
    endtask

    task automatic test_history();
        int vals[3] = '{100, 40, 10};
        test_reset();
        for (int f = 0; f < 3; f++) begin
            frame_vals.delete();
            for (int i = 0; i < 26; i++) frame_vals.push_back(vals[f]);
            send_frame();
        end
        wait_drain();
    endtask

    task automatic test_malformed();
        int ea0 = err_pulses_a;
        int eb0 = err_pulses_b;
        ramp(6);
        send_frame();
        wait_drain();
        checks += 2;
        if (err_pulses_a !== ea0 + 1) begin
            errors++;
            $display("FAIL short_err: got %0d pulses, need 1", err_pulses_a - ea0);
        end
        if (err_pulses_b !== eb0 + 1) begin
            errors++;
            $display("FAIL short_err_skip: got %0d pulses, need 1", err_pulses_b - eb0);
        end
        ea0 = err_pulses_a;
        ramp(30);
        send_frame();
        wait_drain();
        checks++;
        if (err_pulses_a !== ea0 + 1) begin
            errors++;
            $display("FAIL long_err: got %0d pulses, need 1", err_pulses_a - ea0);
        end
    endtask

    task automatic test_back_to_back();
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame_vals.delete();
            for (int i = 0; i < 26; i++) frame_vals.push_back(int'($urandom_range(0, 65535)));
            send_frame();
        end
        wait_drain();
        rand_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int h0;
        int guard = 0;
        ramp(26);
        send_frame();
        h0 = hs_a;
        while (hs_a < h0 + 4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL mid_emit: got %0d words, need 4", hs_a - h0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, need 0", valid_a); end
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got %b, need 0", valid_a); end
        ramp(26);
        send_frame();
        wait_drain();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_ramp();
        test_history();
        test_malformed();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
